// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings for the multicycle MIPS-subset controller
package multicycle_ctrl_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXE    = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;

    localparam logic       SRCA_RS    = 1'b0;
    localparam logic       SRCA_C16   = 1'b1;
    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_ZIMM  = 2'b01;
    localparam logic [1:0] SRCB_SIMM  = 2'b10;

    localparam logic [1:0] PC_PLUS4   = 2'b00;
    localparam logic [1:0] PC_BRANCH  = 2'b01;
    localparam logic [1:0] PC_JUMP    = 2'b10;
    localparam logic [1:0] PC_RS      = 2'b11;

    localparam logic [1:0] DST_RT     = 2'b00;
    localparam logic [1:0] DST_RD     = 2'b01;
    localparam logic [1:0] DST_R31    = 2'b10;

    localparam logic [1:0] WD_ALU     = 2'b00;
    localparam logic [1:0] WD_MEM     = 2'b01;
    localparam logic [1:0] WD_PC4     = 2'b10;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;

    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic nop;
    } instr_flags_t;

endpackage

// File: rtl/multicycle_ctrl_instr_decode.sv
// rtl/multicycle_ctrl_instr_decode.sv - one-hot classification of opcode/funct
module instr_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0]   op,
    input  logic [5:0]   funct,
    output instr_flags_t flags
);

    always_comb begin
        flags       = '0;
        flags.addu  = (op == OP_RTYPE) && (funct == FN_ADDU);
        flags.subu  = (op == OP_RTYPE) && (funct == FN_SUBU);
        flags.jr    = (op == OP_RTYPE) && (funct == FN_JR);
        flags.ori   = (op == OP_ORI);
        flags.lui   = (op == OP_LUI);
        flags.lw    = (op == OP_LW);
        flags.sw    = (op == OP_SW);
        flags.beq   = (op == OP_BEQ);
        flags.j     = (op == OP_J);
        flags.jal   = (op == OP_JAL);
        // Anything unrecognised retires as a two-cycle no-op.
        flags.nop   = ~(flags.addu | flags.subu | flags.jr | flags.ori | flags.lui |
                        flags.lw | flags.sw | flags.beq | flags.j | flags.jal);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - five-state multicycle control FSM with decoded control outputs
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic [2:0]  ALUOp,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        PCWrite,
    output logic [1:0]  PCSrc,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [2:0]  state,
    output logic        instr_done
);

    instr_flags_t f;
    logic [2:0]   state_q;
    logic [2:0]   state_d;
    logic         unused_instr_bits;

    assign unused_instr_bits = ^instr[25:6];

    instr_decode u_decode (
        .op    (instr[31:26]),
        .funct (instr[5:0]),
        .flags (f)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = (f.j | f.jal | f.jr | f.nop) ? ST_FETCH : ST_EXE;
            ST_EXE: begin
                if (f.beq)            state_d = ST_FETCH;
                else if (f.lw | f.sw) state_d = ST_MEM;
                else                  state_d = ST_WB;
            end
            ST_MEM:    state_d = f.sw ? ST_FETCH : ST_WB;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        ALUOp      = ALU_ADD;
        ALUSrcA    = SRCA_RS;
        ALUSrcB    = SRCB_RT;
        PCWrite    = 1'b0;
        PCSrc      = PC_PLUS4;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = DST_RT;
        MemtoReg   = WD_ALU;
        instr_done = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
                ST_DECODE: begin
                    if (f.j | f.jal) begin
                        PCWrite    = 1'b1;
                        PCSrc      = PC_JUMP;
                        instr_done = 1'b1;
                        if (f.jal) begin
                            RegWrite = 1'b1;
                            RegDst   = DST_R31;
                            MemtoReg = WD_PC4;
                        end
                    end else if (f.jr) begin
                        PCWrite    = 1'b1;
                        PCSrc      = PC_RS;
                        instr_done = 1'b1;
                    end else if (f.nop) begin
                        instr_done = 1'b1;
                    end
                end
                ST_EXE, ST_MEM, ST_WB: begin
                    // Selects derive from the held instruction, so they stay put from EXE to WB.
                    if (f.subu | f.beq) ALUOp = ALU_SUB;
                    else if (f.ori)     ALUOp = ALU_OR;
                    else if (f.lui)     ALUOp = ALU_SLL;
                    if (f.lui)             ALUSrcA = SRCA_C16;
                    if (f.ori | f.lui)     ALUSrcB = SRCB_ZIMM;
                    else if (f.lw | f.sw)  ALUSrcB = SRCB_SIMM;
                    if (f.addu | f.subu)   RegDst   = DST_RD;
                    if (f.lw)              MemtoReg = WD_MEM;
                    if (state_q == ST_EXE && f.beq) begin
                        PCWrite    = zero;
                        PCSrc      = PC_BRANCH;
                        instr_done = 1'b1;
                    end
                    if (state_q == ST_MEM && f.sw) begin
                        MemWrite   = 1'b1;
                        instr_done = 1'b1;
                    end
                    if (state_q == ST_WB) begin
                        RegWrite   = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic [2:0]  ALUOp;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        PCWrite;
    logic [1:0]  PCSrc;
    logic        IRWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic [1:0]  RegDst;
    logic [1:0]  MemtoReg;
    logic [2:0]  state;
    logic        instr_done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        logic [2:0]  st;
        logic [16:0] word;
        string       name;
    } vec_t;

    vec_t tab[$];
    vec_t sb[$];

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .zero       (zero),
        .ALUOp      (ALUOp),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCWrite    (PCWrite),
        .PCSrc      (PCSrc),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .state      (state),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCSrc,IRWrite,MemWrite,RegWrite,RegDst,MemtoReg,ALUOp,ALUSrcA,ALUSrcB,instr_done}
    function automatic logic [16:0] w(input logic pcw, input logic [1:0] pcs, input logic irw,
                                      input logic mw, input logic rw, input logic [1:0] rd,
                                      input logic [1:0] m2r, input logic [2:0] op,
                                      input logic sa, input logic [1:0] sbv, input logic done);
        return {pcw, pcs, irw, mw, rw, rd, m2r, op, sa, sbv, done};
    endfunction

    function automatic logic [16:0] got_word();
        return {PCWrite, PCSrc, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg,
                ALUOp, ALUSrcA, ALUSrcB, instr_done};
    endfunction

    task automatic add(input logic [31:0] i, input logic z, input logic [2:0] s,
                       input logic [16:0] wd, input string n);
        vec_t v;
        v.instr = i; v.zero = z; v.st = s; v.word = wd; v.name = n;
        tab.push_back(v);
    endtask

    // Called just after a rising edge: drive, queue expectation, compare at the falling edge.
    task automatic apply(input vec_t v);
        vec_t e;
        logic [16:0] g;
        instr = v.instr;
        zero  = v.zero;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        g = got_word();
        total++;
        if (state !== e.st || g !== e.word) begin
            bad++;
            $display("FAIL %s: got state=%0d ctrl=%05h, want state=%0d ctrl=%05h",
                     e.name, state, g, e.st, e.word);
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADDU = 32'h00221821;
    localparam logic [31:0] I_SUBU = 32'h00221823;
    localparam logic [31:0] I_ORI  = 32'h34211234;
    localparam logic [31:0] I_LUI  = 32'h3C011234;
    localparam logic [31:0] I_LW   = 32'h8C220004;
    localparam logic [31:0] I_SW   = 32'hAC220004;
    localparam logic [31:0] I_BEQ  = 32'h10220003;
    localparam logic [31:0] I_J    = 32'h08000010;
    localparam logic [31:0] I_JAL  = 32'h0C000010;
    localparam logic [31:0] I_JR   = 32'h03E00008;
    localparam logic [31:0] I_BAD  = 32'hFC000000;
    localparam logic [31:0] I_SLL0 = 32'h00000000;

    initial begin
        logic [16:0] fw;
        logic [16:0] zw;
        vec_t v;
        fw = w(1, 2'd0, 1, 0, 0, 2'd0, 2'd0, 3'd0, 0, 2'd0, 0);
        zw = '0;

        add(I_ADDU, 0, 3'd0, fw, "addu_fetch");
        add(I_ADDU, 0, 3'd1, zw, "addu_decode");
        add(I_ADDU, 0, 3'd2, w(0, 2'd0, 0, 0, 0, 2'd1, 2'd0, 3'd0, 0, 2'd0, 0), "addu_exe");
        add(I_ADDU, 0, 3'd4, w(0, 2'd0, 0, 0, 1, 2'd1, 2'd0, 3'd0, 0, 2'd0, 1), "addu_wb");
        add(I_SUBU, 0, 3'd0, fw, "subu_fetch");
        add(I_SUBU, 0, 3'd1, zw, "subu_decode");
        add(I_SUBU, 0, 3'd2, w(0, 2'd0, 0, 0, 0, 2'd1, 2'd0, 3'd1, 0, 2'd0, 0), "subu_exe");
        add(I_SUBU, 0, 3'd4, w(0, 2'd0, 0, 0, 1, 2'd1, 2'd0, 3'd1, 0, 2'd0, 1), "subu_wb");
        add(I_ORI,  0, 3'd0, fw, "ori_fetch");
        add(I_ORI,  0, 3'd1, zw, "ori_decode");
        add(I_ORI,  0, 3'd2, w(0, 2'd0, 0, 0, 0, 2'd0, 2'd0, 3'd2, 0, 2'd1, 0), "ori_exe");
        add(I_ORI,  0, 3'd4, w(0, 2'd0, 0, 0, 1, 2'd0, 2'd0, 3'd2, 0, 2'd1, 1), "ori_wb");
        add(I_LUI,  0, 3'd0, fw, "lui_fetch");
        add(I_LUI,  0, 3'd1, zw, "lui_decode");
        add(I_LUI,  0, 3'd2, w(0, 2'd0, 0, 0, 0, 2'd0, 2'd0, 3'd3, 1, 2'd1, 0), "lui_exe");
        add(I_LUI,  0, 3'd4, w(0, 2'd0, 0, 0, 1, 2'd0, 2'd0, 3'd3, 1, 2'd1, 1), "lui_wb");
        add(I_LW,   0, 3'd0, fw, "lw_fetch");
        add(I_LW,   0, 3'd1, zw, "lw_decode");
        add(I_LW,   0, 3'd2, w(0, 2'd0, 0, 0, 0, 2'd0, 2'd1, 3'd0, 0, 2'd2, 0), "lw_exe");
        add(I_LW,   0, 3'd3, w(0, 2'd0, 0, 0, 0, 2'd0, 2'd1, 3'd0, 0, 2'd2, 0), "lw_mem");
        add(I_LW,   0, 3'd4, w(0, 2'd0, 0, 0, 1, 2'd0, 2'd1, 3'd0, 0, 2'd2, 1), "lw_wb");
        add(I_SW,   0, 3'd0, fw, "sw_fetch");
        add(I_SW,   0, 3'd1, zw, "sw_decode");
        add(I_SW,   0, 3'd2, w(0, 2'd0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 0, 2'd2, 0), "sw_exe");
        add(I_SW,   0, 3'd3, w(0, 2'd0, 0, 1, 0, 2'd0, 2'd0, 3'd0, 0, 2'd2, 1), "sw_mem");
        add(I_BEQ,  1, 3'd0, fw, "beq_t_fetch");
        add(I_BEQ,  1, 3'd1, zw, "beq_t_decode");
        add(I_BEQ,  1, 3'd2, w(1, 2'd1, 0, 0, 0, 2'd0, 2'd0, 3'd1, 0, 2'd0, 1), "beq_t_exe");
        add(I_BEQ,  0, 3'd0, fw, "beq_nt_fetch");
        add(I_BEQ,  0, 3'd1, zw, "beq_nt_decode");
        add(I_BEQ,  0, 3'd2, w(0, 2'd1, 0, 0, 0, 2'd0, 2'd0, 3'd1, 0, 2'd0, 1), "beq_nt_exe");
        add(I_J,    0, 3'd0, fw, "j_fetch");
        add(I_J,    0, 3'd1, w(1, 2'd2, 0, 0, 0, 2'd0, 2'd0, 3'd0, 0, 2'd0, 1), "j_decode");
        add(I_JAL,  0, 3'd0, fw, "jal_fetch");
        add(I_JAL,  0, 3'd1, w(1, 2'd2, 0, 0, 1, 2'd2, 2'd2, 3'd0, 0, 2'd0, 1), "jal_decode");
        add(I_JR,   0, 3'd0, fw, "jr_fetch");
        add(I_JR,   0, 3'd1, w(1, 2'd3, 0, 0, 0, 2'd0, 2'd0, 3'd0, 0, 2'd0, 1), "jr_decode");
        add(I_BAD,  1, 3'd0, fw, "unk_fetch");
        add(I_BAD,  1, 3'd1, w(0, 2'd0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 0, 2'd0, 1), "unk_decode");
        add(I_SLL0, 0, 3'd0, fw, "sll_fetch");
        add(I_SLL0, 0, 3'd1, w(0, 2'd0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 0, 2'd0, 1), "sll_decode");
        add(I_ADDU, 0, 3'd0, fw, "back_to_fetch");

        reset = 1'b1;
        instr = I_ORI;
        zero  = 1'b0;
        @(negedge clk);
        total++;
        if (got_word() !== 17'd0) begin
            bad++;
            $display("FAIL reset_outputs: got ctrl=%05h, want 00000", got_word());
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL reset_state: got %0d, want 0", state);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < tab.size(); i++) begin
            apply(tab[i]);
        end

        // Reset during EXE of ori: the register write must never appear.
        v.instr = I_ORI; v.zero = 0;
        v.st = 3'd1; v.word = zw; v.name = "rst_ori_decode";
        apply(v);
        reset = 1'b1;
        v.st = 3'd2; v.word = zw; v.name = "rst_ori_exe_held";
        apply(v);
        reset = 1'b0;
        v.st = 3'd0; v.word = fw; v.name = "rst_release_fetch";
        apply(v);
        v.st = 3'd1; v.word = zw; v.name = "rst_refetch_decode";
        apply(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
